// File: rtl/fault_monitor_pkg.sv
// Shared types and constants for the fault monitor: channel FSM encoding,
// gap counter width and the index-width helper.
package fault_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TEST = 2'd1,
    ST_GAP  = 2'd2,
    ST_TRIP = 2'd3
  } chan_state_t;

  localparam int GCNT_W = 8;

  // Index width that stays legal for a single-channel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fault_monitor_if.sv
// Pin-level bundle between the fault sources/controls and the fault monitor.
interface fault_monitor_if
  import fault_monitor_pkg::*;
#(
  parameter int N_CH = 4
);
  localparam int IDX_W = idx_width(N_CH);

  logic [N_CH-1:0]  fault_in;
  logic [N_CH-1:0]  ch_en;
  logic [N_CH-1:0]  clr;
  logic [N_CH-1:0]  fault_out;
  logic             fault_any;
  logic [IDX_W-1:0] first_idx;
  logic             first_valid;

  modport master (
    output fault_in, ch_en, clr,
    input  fault_out, fault_any, first_idx, first_valid
  );

  modport slave (
    input  fault_in, ch_en, clr,
    output fault_out, fault_any, first_idx, first_valid
  );
endinterface

// File: rtl/fault_monitor_chan.sv
// One fault channel: input synchroniser, burst qualification FSM with gap
// tolerance, and the registered trip flag.
module fault_chan
  import fault_monitor_pkg::*;
#(
  parameter int   CNT_W    = 24,
  parameter int   T_ASSERT = 1000000,
  parameter int   GAP_MAX  = 1,
  parameter logic ACT_LOW  = 1'b1,
  parameter logic STICKY   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic fault_pin,
  input  logic en,
  input  logic clr,
  output logic fault_out,
  output logic enter_trip
);

  localparam logic [CNT_W-1:0]  T_VAL = CNT_W'(T_ASSERT);
  localparam logic [GCNT_W-1:0] GAP_V = GCNT_W'(GAP_MAX);

  logic [1:0]        sync_r;
  logic              act_s;
  chan_state_t       state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [GCNT_W-1:0] gcnt_r;
  logic              enter_trip_s;

  // Two-flop synchroniser, reset to the pin's inactive level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {2{ACT_LOW}};
    end else begin
      sync_r <= {sync_r[0], fault_pin};
    end
  end

  assign act_s     = sync_r[1] ^ ACT_LOW;
  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // Trip is taken on the edge where the incremented count reaches the threshold.
  always_comb begin
    enter_trip_s = 1'b0;
    if (en && act_s) begin
      case (state_r)
        ST_IDLE: enter_trip_s = (T_VAL == CNT_W'(1));
        ST_TEST: enter_trip_s = (cnt_inc_s == T_VAL);
        ST_GAP:  enter_trip_s = (cnt_inc_s == T_VAL);
        default: enter_trip_s = 1'b0;
      endcase
    end else begin
      enter_trip_s = 1'b0;
    end
  end

  assign enter_trip = enter_trip_s;

  // Qualification FSM; fault_out powers up asserted until the first clean sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      gcnt_r    <= '0;
      fault_out <= 1'b1;
    end else if (!en) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      gcnt_r    <= '0;
      fault_out <= 1'b0;
    end else if (enter_trip_s) begin
      state_r   <= ST_TRIP;
      cnt_r     <= T_VAL;
      gcnt_r    <= '0;
      fault_out <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          gcnt_r    <= '0;
          fault_out <= 1'b0;
          if (act_s) begin
            cnt_r   <= CNT_W'(1);
            state_r <= ST_TEST;
          end else begin
            cnt_r   <= '0;
          end
        end
        ST_TEST: begin
          fault_out <= 1'b0;
          if (act_s) begin
            cnt_r   <= cnt_inc_s;
          end else begin
            gcnt_r  <= GCNT_W'(1);
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          fault_out <= 1'b0;
          if (act_s) begin
            cnt_r   <= cnt_inc_s;
            gcnt_r  <= '0;
            state_r <= ST_TEST;
          end else if (gcnt_r < GAP_V) begin
            gcnt_r  <= gcnt_r + GCNT_W'(1);
          end else begin
            cnt_r   <= '0;
            gcnt_r  <= '0;
            state_r <= ST_IDLE;
          end
        end
        ST_TRIP: begin
          if (STICKY) begin
            // Sticky trips only release once the fault has gone away.
            if (clr && !act_s) begin
              state_r   <= ST_IDLE;
              cnt_r     <= '0;
              gcnt_r    <= '0;
              fault_out <= 1'b0;
            end else begin
              fault_out <= 1'b1;
            end
          end else if (act_s) begin
            gcnt_r    <= '0;
            fault_out <= 1'b1;
          end else if (gcnt_r >= GAP_V) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            gcnt_r    <= '0;
            fault_out <= 1'b0;
          end else begin
            gcnt_r    <= gcnt_r + GCNT_W'(1);
            fault_out <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= '0;
          gcnt_r    <= '0;
          fault_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/fault_monitor.sv
// Multi-channel fault monitor: N_CH qualified fault channels plus
// first-fault capture across channels.
module fault_monitor
  import fault_monitor_pkg::*;
#(
  parameter int              N_CH     = 4,
  parameter int              CNT_W    = 24,
  parameter int              T_ASSERT = 1000000,
  parameter int              GAP_MAX  = 1,
  parameter logic [N_CH-1:0] ACT_LOW  = '1,
  parameter logic [N_CH-1:0] STICKY   = '0
) (
  input logic           clk,
  input logic           reset_n,
  fault_monitor_if.slave bus
);

  localparam int IDX_W = idx_width(N_CH);

  logic [N_CH-1:0]  fault_vec_s;
  logic [N_CH-1:0]  enter_vec_s;
  logic [IDX_W-1:0] low_idx_s;
  logic [IDX_W-1:0] first_idx_r;
  logic             first_valid_r;
  logic             all_clear_s;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    fault_chan #(
      .CNT_W    (CNT_W),
      .T_ASSERT (T_ASSERT),
      .GAP_MAX  (GAP_MAX),
      .ACT_LOW  (ACT_LOW[i]),
      .STICKY   (STICKY[i])
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .fault_pin  (bus.fault_in[i]),
      .en         (bus.ch_en[i]),
      .clr        (bus.clr[i]),
      .fault_out  (fault_vec_s[i]),
      .enter_trip (enter_vec_s[i])
    );
  end

  // Lowest-numbered channel entering TRIP this cycle wins the arbitration.
  always_comb begin
    low_idx_s = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (enter_vec_s[i]) begin
        low_idx_s = IDX_W'(i);
      end else begin
        low_idx_s = low_idx_s;
      end
    end
  end

  assign all_clear_s = (fault_vec_s == '0);

  // First-fault latch; released one edge after every trip flag has dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_valid_r <= 1'b0;
      first_idx_r   <= '0;
    end else if ((|enter_vec_s) && (!first_valid_r || all_clear_s)) begin
      first_valid_r <= 1'b1;
      first_idx_r   <= low_idx_s;
    end else if (all_clear_s) begin
      first_valid_r <= 1'b0;
    end else begin
      first_valid_r <= first_valid_r;
    end
  end

  assign bus.fault_out   = fault_vec_s;
  assign bus.fault_any   = |fault_vec_s;
  assign bus.first_idx   = first_idx_r;
  assign bus.first_valid = first_valid_r;

endmodule

// File: doc/fault_monitor.md
FAULT_MONITOR -- requirements
Module: fault_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent fault channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 24: width of the per-channel qualification counter.
REQ-003 SHALL have parameter T_ASSERT, default 1000000: consecutive active samples required to trip (1..2^CNT_W-1).
REQ-004 SHALL have parameter GAP_MAX, default 1: maximum inactive run tolerated inside a qualifying burst, in cycles (0..255).
REQ-005 SHALL have parameter ACT_LOW, default all-ones [N_CH]: per-channel polarity; 1 means the input is active-low.
REQ-006 SHALL have parameter STICKY, default all-zeros [N_CH]: per-channel latch mode; 1 means a trip holds until cleared.
REQ-007 clk  in  1  sole clock; all logic rising-edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 fault_in  in  N_CH  raw asynchronous fault pins.
REQ-010 ch_en  in  N_CH  per-channel enable; 0 forces the channel idle.
REQ-011 clr  in  N_CH  per-channel single-cycle clear for sticky trips.
REQ-012 fault_out  out  N_CH  registered per-channel trip flag; 1 = protect.
REQ-013 fault_any  out  1  OR of fault_out.
REQ-014 first_idx  out  $clog2(N_CH)  index of the first channel to trip.
REQ-015 first_valid  out  1  first_idx holds a valid index.

Function
REQ-016 Each fault_in bit SHALL pass through a 2-flop synchroniser; act[i] = sync[i] XOR ACT_LOW[i].
REQ-017 Each channel SHALL run an FSM with states IDLE, TEST, GAP and TRIP, holding counter cnt (CNT_W bits) and gap counter gcnt (8 bits).
REQ-018 In IDLE: on act, cnt becomes 1 and the FSM moves to TEST; otherwise cnt becomes 0.
REQ-019 In TEST: on act, cnt increments; on !act, the FSM moves to GAP with gcnt = 1 and cnt held.
REQ-020 In GAP: on act, cnt increments and the FSM returns to TEST; on !act with gcnt < GAP_MAX, gcnt increments; on !act with gcnt >= GAP_MAX, cnt clears and the FSM returns to IDLE.
REQ-021 When an increment makes cnt equal T_ASSERT, the FSM SHALL enter TRIP and fault_out[i] SHALL be 1 on that same edge; cnt saturates at T_ASSERT and never wraps.
REQ-022 In TRIP with STICKY[i] = 0: after GAP_MAX+1 consecutive !act cycles the FSM enters IDLE and fault_out[i] goes 0; any act restarts that run.
REQ-023 In TRIP with STICKY[i] = 1: the FSM leaves TRIP only when clr[i] = 1 and act = 0 in the same cycle; clr while active SHALL be ignored.
REQ-024 clr SHALL have no effect outside TRIP.
REQ-025 ch_en[i] = 0 SHALL force IDLE, cnt = 0 and fault_out[i] = 0 on the next edge, overriding all other inputs including a trip in progress.
REQ-026 Pin-to-fault_out latency for a continuous fault SHALL be T_ASSERT+2 cycles.
REQ-027 first_valid SHALL set on the edge at which any channel enters TRIP while first_valid = 0, latching first_idx; on simultaneous trips, the lowest index wins.
REQ-028 first_valid SHALL clear on the edge after fault_out becomes all-zero, unless a new trip occurs in that cycle, in which case REQ-027 applies.

Reset
REQ-029 On reset_n low: fault_out = all-ones (fail-safe), state = IDLE, cnt = 0, gcnt = 0, synchronisers = inactive level, first_valid = 0, first_idx = 0.
REQ-030 On the first edge after reset release, channels in IDLE with act = 0 SHALL drive fault_out = 0.
REQ-031 Asserting reset mid-operation SHALL discard all counts and latched trips.

Structure
REQ-032 The state encoding (IDLE = 0, TEST = 1, GAP = 2, TRIP = 3) and the GAP counter width SHALL live in package fault_monitor_pkg.
REQ-033 Per-channel logic (synchroniser, FSM, counters) SHALL be sub-module fault_chan, instantiated N_CH times by generate; first-fault arbitration SHALL stay in the top level.

Verification (N_CH=4, T_ASSERT=8, GAP_MAX=1, ACT_LOW=4'hF, STICKY=4'b0010)
REQ-034 fault_in[0] low for 20 cycles: fault_out[0] rises 10 cycles after the first low, then falls 4 cycles after release.
REQ-035 fault_in[0] low 5 cycles, high 1 cycle, low 3 cycles: trips (gap tolerated); the same pattern with a 2-cycle high does not trip.
REQ-036 Ch1 trips, then fault_in[1] is released: fault_out[1] stays 1; clr[1] pulse gives 0 next edge; clr[1] while low has no effect.
REQ-037 Ch2 and ch3 go low on the same cycle: both trip, first_idx = 2, first_valid = 1; first_valid clears after both release.
REQ-038 ch_en[3] dropped mid-TEST at cnt = 5 and reasserted: count restarts from 0, so a trip needs 8 new samples.
REQ-039 Reset asserted while ch1 is in TRIP: outputs read 4'hF during reset and 4'h0 one edge after release with inputs inactive.
